// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU front-end definitions: the fetch state type and the opcode
// classification helpers used by the fetch sequencer and the decoder.
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    ST_FETCH0  = 3'd0,
    ST_FETCH1  = 3'd1,
    ST_FETCH2  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_LOCKED  = 3'd4
  } fetch_state_e;

  // Total instruction size in bytes, derived from the first opcode byte.
  // A CB prefix always carries exactly one more byte.
  function automatic logic [1:0] instr_length(input logic [7:0] byte0);
    logic [1:0] len;
    case (byte0)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        len = 2'd3;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

  // Undefined opcodes that freeze the CPU until reset.
  function automatic logic is_hard_lock(input logic [7:0] byte0);
    logic hit;
    case (byte0)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
        hit = 1'b1;
      default:
        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gb_cpu_fetch_sequencer.sv
// Instruction fetch front end: reads opcode bytes one at a time, sizes and
// packs each instruction, hands it to the decoder over valid/ready, owns the
// PC and parks on hard-lock opcodes.
module gb_cpu_fetch_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [23:0] instruction,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        locked
);

  fetch_state_e state;
  logic [15:0]  pc;

  // Fetch/present sequencing; a request is raised only from a cycle where it
  // is low, so every byte costs at least one idle cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH0;
      pc          <= RESET_PC;
      mem_rd_req  <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_len   <= '0;
      instr_pc    <= '0;
      locked      <= 1'b0;
    end else if (pc_load && state != ST_LOCKED) begin
      pc          <= pc_load_value;
      state       <= ST_FETCH0;
      mem_rd_req  <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
    end else begin
      case (state)
        ST_FETCH0: begin
          if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= pc;
          end else if (mem_rd_valid) begin
            mem_rd_req  <= 1'b0;
            pc          <= pc + 16'd1;
            instr_pc    <= pc;
            instruction <= {mem_rd_data, 16'h0000};
            instr_len   <= instr_length(mem_rd_data);
            if (is_hard_lock(mem_rd_data)) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else if (instr_length(mem_rd_data) == 2'd1) begin
              state       <= ST_PRESENT;
              instr_valid <= 1'b1;
            end else begin
              state <= ST_FETCH1;
            end
          end
        end
        ST_FETCH1: begin
          if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= pc;
          end else if (mem_rd_valid) begin
            mem_rd_req         <= 1'b0;
            pc                 <= pc + 16'd1;
            instruction[15:8]  <= mem_rd_data;
            if (instr_len == 2'd3) begin
              state <= ST_FETCH2;
            end else begin
              state       <= ST_PRESENT;
              instr_valid <= 1'b1;
            end
          end
        end
        ST_FETCH2: begin
          if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= pc;
          end else if (mem_rd_valid) begin
            mem_rd_req        <= 1'b0;
            pc                <= pc + 16'd1;
            instruction[7:0]  <= mem_rd_data;
            state             <= ST_PRESENT;
            instr_valid       <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            instruction <= '0;
            state       <= ST_FETCH0;
          end
        end
        ST_LOCKED: begin
          mem_rd_req  <= 1'b0;
          instr_valid <= 1'b0;
          locked      <= 1'b1;
        end
        default: begin
          state <= ST_FETCH0;
        end
      endcase
    end
  end

endmodule
